// File: rtl/led_pkg.sv
// Shared display definitions used by the display arbiter and the LED bank driver.
`timescale 1ns/1ps
package led_pkg;

  localparam int DISP_W  = 32;
  localparam int DIGIT_W = 4;
  localparam int NDIGITS = DISP_W / DIGIT_W;

  typedef enum logic {IDLE, HOLD} disp_state_t;

endpackage

// File: rtl/led_disp_arb_rr_arb.sv
// Combinational round-robin arbiter: rotate requests to the pointer, pick the
// lowest set bit, rotate the one-hot grant back.
`timescale 1ns/1ps
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] pointer,
  output logic [NREQ-1:0]         grant
);

  logic [NREQ-1:0] req_rot;
  logic [NREQ-1:0] gnt_rot;

  always_comb begin
    req_rot = '0;
    gnt_rot = '0;
    grant   = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rot[i] = req[(i + int'(pointer)) % NREQ];
    end
    // Walk from the top down so the lowest rotated index wins
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        gnt_rot    = '0;
        gnt_rot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[(i + int'(pointer)) % NREQ] = gnt_rot[i];
    end
  end

endmodule

// File: rtl/led_disp_arb.sv
// Display arbiter: grants one debug source the seven-segment value for a
// minimum hold time, rotates grants round-robin, and generates the scan strobe.
`timescale 1ns/1ps
module led_disp_arb
  import led_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int SCAN_DIV    = 50_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DISP_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DISP_W-1:0]        digits,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic                     scan_tick
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV);

  disp_state_t       state;
  logic [OW-1:0]     ptr;
  logic [OW-1:0]     gnt_idx;
  logic [OW-1:0]     next_ptr;
  logic [OW-1:0]     sel_idx;
  logic [NREQ-1:0]   grant;
  logic [DISP_W-1:0] sel_data;
  logic              owner_valid;
  logic [HW-1:0]     hold_cnt;
  logic [SW-1:0]     scan_cnt;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req     (req_valid),
    .pointer (ptr),
    .grant   (grant)
  );

  always_comb begin
    gnt_idx     = '0;
    sel_data    = '0;
    owner_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_idx = OW'(i);
    end
    next_ptr = (gnt_idx == OW'(NREQ - 1)) ? '0 : gnt_idx + OW'(1);
    sel_idx  = (state == IDLE) ? gnt_idx : owner;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == sel_idx) sel_data = req_data[i*DISP_W +: DISP_W];
      if (OW'(i) == owner)   owner_valid = req_valid[i];
    end
  end

  // Ready is held low while reset is asserted so no transfer can be signalled
  always_comb begin
    req_ready = '0;
    if (rst) begin
      if (state == IDLE) begin
        req_ready = grant;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (OW'(i) == owner) req_ready[i] = req_valid[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      digits   <= '0;
      owner    <= '0;
      ptr      <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            digits   <= sel_data;
            owner    <= gnt_idx;
            ptr      <= next_ptr;
            hold_cnt <= HW'(HOLD_CYCLES - 1);
            busy     <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // Owner refreshes the value without extending its hold window
          if (owner_valid) digits <= sel_data;
          if (hold_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= (scan_cnt == SW'(SCAN_DIV - 1));
      scan_cnt  <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_led_disp_arb.sv
// Bench for led_disp_arb: directed scenarios plus random requesters, all checked
// against a cycle-level model of the grant/hold/scan rules.
`timescale 1ns/1ps
module tb_led_disp_arb;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int SDIV = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  digits;
  logic [1:0]   owner;
  logic         busy;
  logic         scan_tick;

  led_disp_arb #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .SCAN_DIV(SDIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .digits    (digits),
    .owner     (owner),
    .busy      (busy),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: hold_left counts remaining busy cycles; cyc counts edges since release
  logic [31:0] m_digits;
  int          m_owner;
  int          m_ptr;
  int          hold_left;
  int          cyc;
  logic [3:0]  m_xfer;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [127:0] d);
    req_valid = v;
    req_data  = d;
  endtask

  task automatic modelReset();
    m_digits  = '0;
    m_owner   = 0;
    m_ptr     = 0;
    hold_left = 0;
    cyc       = 0;
    m_xfer    = '0;
  endtask

  // Called at posedge+1; asserts reset mid-cycle, checks outputs at once, releases after next edge
  task automatic doReset();
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_digits", digits, 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_tick", 32'(scan_tick), 32'h0);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic runCycle();
    logic [3:0] exp_ready;
    int         g;
    bit         found;
    @(negedge clk);
    exp_ready = '0;
    found     = 0;
    if (hold_left == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        g = (m_ptr + k) % NREQ;
        if (!found && req_valid[g]) begin
          exp_ready[g] = 1'b1;
          found        = 1;
        end
      end
    end else begin
      exp_ready[m_owner] = req_valid[m_owner];
    end
    checkOutput("ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("digits", digits, m_digits);
    checkOutput("owner", 32'(owner), 32'(m_owner));
    checkOutput("busy", 32'(busy), 32'(hold_left > 0));
    checkOutput("scan_tick", 32'(scan_tick), 32'(cyc > 0 && cyc % SDIV == 0));
    m_xfer = exp_ready & req_valid;
    if (hold_left == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_xfer[k]) begin
          m_digits  = req_data[k*32 +: 32];
          m_owner   = k;
          m_ptr     = (k + 1) % NREQ;
          hold_left = HOLD;
        end
      end
    end else begin
      if (m_xfer != 0) m_digits = req_data[m_owner*32 +: 32];
      hold_left--;
    end
    @(posedge clk);
    #1 cyc++;
  endtask

  function automatic logic [31:0] randBcd();
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    int          busy_cnt;
    int          ticks;
    int          order[5];
    logic [3:0]  v;
    logic [127:0] d;
    order = '{0, 1, 2, 3, 0};
    applyStimulus(4'b0000, '0);
    #1;
    doReset();

    repeat (20) runCycle();

    // Single requester: immediate ready, one-cycle data latency, fixed hold
    applyStimulus(4'b0001, {96'h0, 32'h12345678});
    runCycle();
    applyStimulus(4'b0000, '0);
    checkOutput("single_digits", digits, 32'h12345678);
    checkOutput("single_owner", 32'(owner), 32'h0);
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (busy) busy_cnt++;
      runCycle();
    end
    checkOutput("single_busy_len", 32'(busy_cnt), 32'(HOLD));

    // All requesters valid: strict rotation from pointer 0
    doReset();
    applyStimulus(4'b1111, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    for (int c = 0; c < 25; c++) begin
      if (c % 5 == 1) checkOutput("rr_order", 32'(owner), 32'(order[c/5]));
      runCycle();
    end
    applyStimulus(4'b0000, '0);
    repeat (5) runCycle();

    // Owner update mid-hold while another requester waits
    doReset();
    applyStimulus(4'b0010, {64'h0, 32'h00000042, 32'h0});
    runCycle();
    applyStimulus(4'b0110, {32'h0, 32'h55555555, 32'h00000099, 32'h0});
    runCycle();
    checkOutput("upd_digits", digits, 32'h00000099);
    applyStimulus(4'b0100, {32'h0, 32'h55555555, 64'h0});
    repeat (3) runCycle();
    checkOutput("upd_busy_end", 32'(busy), 32'h0);
    checkOutput("upd_ready2", 32'(req_ready), 32'h4);
    runCycle();
    checkOutput("upd_owner2", 32'(owner), 32'h2);
    checkOutput("upd_digits2", digits, 32'h55555555);
    applyStimulus(4'b0000, '0);
    repeat (5) runCycle();

    // Reset in the second hold cycle, then arbitration restarts at pointer 0
    applyStimulus(4'b0100, {32'h0, 32'h00000077, 64'h0});
    runCycle();
    applyStimulus(4'b0000, '0);
    runCycle();
    doReset();
    applyStimulus(4'b1010, {32'h00000031, 32'h0, 32'h00000013, 32'h0});
    runCycle();
    checkOutput("post_rst_owner", 32'(owner), 32'h1);
    checkOutput("post_rst_digits", digits, 32'h00000013);
    applyStimulus(4'b1000, {32'h00000031, 96'h0});
    repeat (4) runCycle();
    runCycle();
    applyStimulus(4'b0000, '0);
    repeat (5) runCycle();

    // Free-running scan strobe
    doReset();
    ticks = 0;
    for (int c = 0; c < 30; c++) begin
      if (scan_tick) ticks++;
      runCycle();
    end
    checkOutput("scan_ticks", 32'(ticks), 32'h5);

    // Random requesters obeying the hold-until-accepted rule
    v = '0;
    d = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || m_xfer[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            v[i]          = 1'b1;
            d[i*32 +: 32] = randBcd();
          end else begin
            v[i] = 1'b0;
          end
        end
      end
      applyStimulus(v, d);
      runCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
